hh_spike_encoder: RTL and testbench

Consumes the membrane-voltage stream produced by the hh neuron core and encodes it back into the network domain.
- Detects action potentials using a hysteretic threshold and enforces a refractory window.
- Measures inter-spike interval (ISI) and keeps a spike count.
- Generates a decaying synaptic current in the same Q9.5 format as the neuron's current input, so it can drive a downstream hh instance.

---
 rtl/hh_pkg.sv | 31 +++
 rtl/hh_syn_decay.sv | 41 ++++
 rtl/hh_spike_encoder.sv | 124 ++++++++++++
 tb/tb_hh_spike_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hh_pkg.sv
// Shared Q9.5 constants, encoder FSM encoding and the saturating adder
// used by both the hh core current path and the spike encoder.
package hh_pkg;

    localparam int HH_W    = 14;
    localparam int HH_FRAC = 5;

    // Voltages in Q9.5 (1 mV = 32 LSB).
    localparam logic [HH_W-1:0] V_REST        = 14'h37E0;
    localparam logic [HH_W-1:0] THRESH_HI_DEF = 14'h0000;
    localparam logic [HH_W-1:0] THRESH_LO_DEF = 14'h3B00;

    typedef enum logic [1:0] {
        ST_BELOW   = 2'd0,
        ST_ABOVE   = 2'd1,
        ST_REFRAC  = 2'd2,
        ST_ILLEGAL = 2'd3
    } enc_state_t;

    // Signed add that clamps to the most positive / most negative code.
    function automatic logic [HH_W-1:0] sat_add(input logic [HH_W-1:0] a,
                                                input logic [HH_W-1:0] b);
        logic [HH_W:0] sum;
        sum = {a[HH_W-1], a} + {b[HH_W-1], b};
        if (sum[HH_W] != sum[HH_W-1])
            sat_add = sum[HH_W] ? {1'b1, {(HH_W-1){1'b0}}} : {1'b0, {(HH_W-1){1'b1}}};
        else
            sat_add = sum[HH_W-1:0];
    endfunction

endpackage

// File: rtl/hh_syn_decay.sv
// Synaptic current register: exponential decay per enabled sample plus a
// saturating kick on each spike. Output never goes negative.
module hh_syn_decay
    import hh_pkg::*;
#(
    parameter int             W           = HH_W,
    parameter logic [W-1:0]   W_SYN       = 14'h0140,
    parameter int             DECAY_SHIFT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         kick,
    output logic [W-1:0] i_syn
);

    logic [W-1:0] decay;
    logic [W-1:0] decayed;
    logic [W-1:0] kicked;
    logic [W-1:0] i_next;

    always_comb begin
        decay = i_syn >> DECAY_SHIFT;
        // Force at least one LSB of decay so small currents reach zero.
        if (decay == '0 && i_syn != '0)
            decay = {{(W-1){1'b0}}, 1'b1};
        decayed = i_syn - decay;
        kicked  = sat_add(decayed, W_SYN);
        i_next  = kick ? kicked : decayed;
        if (i_next[W-1])
            i_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            i_syn <= '0;
        else if (en)
            i_syn <= i_next;
    end

endmodule

// File: rtl/hh_spike_encoder.sv
// Converts an hh membrane-voltage stream into spikes with hysteresis and
// refractory gating, plus ISI, spike count and a decaying synaptic current.
module hh_spike_encoder
    import hh_pkg::*;
#(
    parameter int           W           = HH_W,
    parameter logic [W-1:0] THRESH_HI   = THRESH_HI_DEF,
    parameter logic [W-1:0] THRESH_LO   = THRESH_LO_DEF,
    parameter int           REFRAC_SMP  = 64,
    parameter int           ISI_W       = 16,
    parameter int           CNT_W       = 8,
    parameter logic [W-1:0] W_SYN       = 14'h0140,
    parameter int           DECAY_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W-1:0]     v_in,
    input  logic             clr_count,
    output logic             spike,
    output logic             isi_valid,
    output logic [ISI_W-1:0] isi,
    output logic [CNT_W-1:0] spike_count,
    output logic [W-1:0]     i_syn,
    output logic [1:0]       state_o
);

    localparam int RC_W = (REFRAC_SMP > 0) ? $clog2(REFRAC_SMP + 1) : 1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    enc_state_t       state, state_next;
    logic [RC_W-1:0]  rc, rc_next;
    logic [ISI_W-1:0] isi_cnt;
    logic             seen_spike;
    logic             spike_det;
    logic             v_ge_hi, v_lt_lo;

    assign v_ge_hi   = $signed(v_in) >= $signed(THRESH_HI);
    assign v_lt_lo   = $signed(v_in) <  $signed(THRESH_LO);
    assign spike_det = en && (state == ST_BELOW) && v_ge_hi;
    assign state_o   = state;

    always_comb begin
        state_next = state;
        rc_next    = rc;
        case (state)
            ST_BELOW: begin
                if (en && v_ge_hi)
                    state_next = ST_ABOVE;
            end
            ST_ABOVE: begin
                if (en && v_lt_lo) begin
                    if (REFRAC_SMP == 0) begin
                        state_next = ST_BELOW;
                    end else begin
                        state_next = ST_REFRAC;
                        rc_next    = RC_W'(REFRAC_SMP);
                    end
                end
            end
            ST_REFRAC: begin
                // v_in is deliberately ignored here.
                if (en) begin
                    if (rc <= RC_W'(1)) begin
                        state_next = ST_BELOW;
                        rc_next    = '0;
                    end else begin
                        rc_next = rc - RC_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_BELOW;
                rc_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BELOW;
            rc          <= '0;
            spike       <= 1'b0;
            isi_valid   <= 1'b0;
            isi         <= '0;
            isi_cnt     <= '0;
            seen_spike  <= 1'b0;
            spike_count <= '0;
        end else begin
            state     <= state_next;
            rc        <= rc_next;
            spike     <= spike_det;
            isi_valid <= spike_det && seen_spike;

            if (spike_det) begin
                isi        <= (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);
                isi_cnt    <= '0;
                seen_spike <= 1'b1;
            end else if (en && isi_cnt != ISI_MAX) begin
                isi_cnt <= isi_cnt + ISI_W'(1);
            end

            // A clear in the same cycle as a spike leaves that spike counted.
            if (clr_count)
                spike_count <= spike_det ? CNT_W'(1) : '0;
            else if (spike_det && spike_count != CNT_MAX)
                spike_count <= spike_count + CNT_W'(1);
        end
    end

    hh_syn_decay #(
        .W           (W),
        .W_SYN       (W_SYN),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_syn (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .kick  (spike_det),
        .i_syn (i_syn)
    );

endmodule

// File: tb/tb_hh_spike_encoder.sv
// Directed bench for hh_spike_encoder: default instance plus a second
// instance with no refractory, narrow counters and a large synaptic kick.
module tb_hh_spike_encoder;

    localparam logic [13:0] VP10 = 14'h0140;
    localparam logic [13:0] VP5  = 14'h00A0;
    localparam logic [13:0] VM10 = 14'h3EC0;
    localparam logic [13:0] VM65 = 14'h37E0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [13:0] v_in = '0;
    logic        clr_count = 1'b0;

    logic        spike, isi_valid;
    logic [15:0] isi;
    logic [7:0]  spike_count;
    logic [13:0] i_syn;
    logic [1:0]  state_o;

    logic        s_spike, s_isi_valid;
    logic [3:0]  s_isi;
    logic [3:0]  s_count;
    logic [13:0] s_i_syn;
    logic [1:0]  s_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hh_spike_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .v_in(v_in), .clr_count(clr_count),
        .spike(spike), .isi_valid(isi_valid), .isi(isi), .spike_count(spike_count),
        .i_syn(i_syn), .state_o(state_o)
    );

    hh_spike_encoder #(.REFRAC_SMP(0), .ISI_W(4), .CNT_W(4), .W_SYN(14'h0C00)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .v_in(v_in), .clr_count(clr_count),
        .spike(s_spike), .isi_valid(s_isi_valid), .isi(s_isi), .spike_count(s_count),
        .i_syn(s_i_syn), .state_o(s_state)
    );

    task automatic step(input logic e, input logic [13:0] v, input logic c);
        @(negedge clk);
        en = e; v_in = v; clr_count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; clr_count = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; v_in = VP10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({spike, isi_valid, isi, spike_count, i_syn, state_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got spike=%0d isi_valid=%0d isi=%0d cnt=%0d i_syn=%0h state=%0d expected all 0",
                     spike, isi_valid, isi, spike_count, i_syn, state_o);
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        step(1'b1, VP10, 1'b0);
        checks++;
        if (spike !== 1'b1 || isi_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_spike: got spike=%0d isi_valid=%0d expected spike=1 isi_valid=0", spike, isi_valid);
        end
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL reset_first_state: got %0d expected 1", state_o);
        end
    endtask

    task automatic test_single_spike();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, VM65, 1'b0);
            checks++;
            if (spike !== 1'b0 || state_o !== 2'd0) begin
                errors++;
                $display("FAIL single_rest_%0d: got spike=%0d state=%0d expected 0 0", i, spike, state_o);
            end
        end
        step(1'b1, VP10, 1'b0);
        checks++;
        if (spike !== 1'b1 || spike_count !== 8'd1 || i_syn !== 14'h0140) begin
            errors++;
            $display("FAIL single_spike: got spike=%0d cnt=%0d i_syn=%0h expected 1 1 140", spike, spike_count, i_syn);
        end
        step(1'b1, VP10, 1'b0);
        checks++;
        if (spike !== 1'b0 || i_syn !== 14'd280) begin
            errors++;
            $display("FAIL single_decay1: got spike=%0d i_syn=%0d expected 0 280", spike, i_syn);
        end
        step(1'b1, VP10, 1'b0);
        checks++;
        if (i_syn !== 14'd245) begin
            errors++;
            $display("FAIL single_decay2: got i_syn=%0d expected 245", i_syn);
        end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 50; i++) begin
            step(1'b1, (i % 2 == 0) ? VP5 : VM10, 1'b0);
            checks++;
            if (spike !== 1'b0 || state_o !== 2'd1) begin
                errors++;
                $display("FAIL hyst_%0d: got spike=%0d state=%0d expected 0 1", i, spike, state_o);
            end
        end
        checks++;
        if (spike_count !== 8'd1) begin
            errors++;
            $display("FAIL hyst_count: got %0d expected 1", spike_count);
        end
    endtask

    task automatic test_refrac_isi();
        apply_reset();
        step(1'b1, VP10, 1'b0);
        for (int k = 1; k < 100; k++) begin
            step(1'b1, (k >= 10 && k <= 20) ? VP10 : VM65, 1'b0);
            checks++;
            if (spike !== 1'b0) begin
                errors++;
                $display("FAIL refrac_nospike_%0d: got spike=%0d expected 0", k, spike);
            end
            if (k == 64) begin
                checks++;
                if (state_o !== 2'd2) begin
                    errors++;
                    $display("FAIL refrac_last: got state=%0d expected 2", state_o);
                end
            end
            if (k == 65) begin
                checks++;
                if (state_o !== 2'd0) begin
                    errors++;
                    $display("FAIL refrac_end: got state=%0d expected 0", state_o);
                end
            end
        end
        step(1'b1, VP10, 1'b0);
        checks++;
        if (spike !== 1'b1 || isi_valid !== 1'b1 || isi !== 16'd100 || spike_count !== 8'd2) begin
            errors++;
            $display("FAIL isi_100: got spike=%0d isi_valid=%0d isi=%0d cnt=%0d expected 1 1 100 2",
                     spike, isi_valid, isi, spike_count);
        end
    endtask

    task automatic test_en_gating();
        apply_reset();
        step(1'b1, VP10, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, VM65, 1'b0);
        checks++;
        if (i_syn !== 14'd76 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL gate_pre: got i_syn=%0d state=%0d expected 76 2", i_syn, state_o);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, VP10, 1'b0);
            checks++;
            if (spike !== 1'b0 || state_o !== 2'd2 || i_syn !== 14'd76 || spike_count !== 8'd1 || isi_valid !== 1'b0) begin
                errors++;
                $display("FAIL gate_hold_%0d: got spike=%0d state=%0d i_syn=%0d cnt=%0d expected 0 2 76 1",
                         i, spike, state_o, i_syn, spike_count);
            end
        end
        for (int i = 0; i < 53; i++) step(1'b1, VP10, 1'b0);
        checks++;
        if (state_o !== 2'd2 || spike !== 1'b0) begin
            errors++;
            $display("FAIL gate_resume_53: got state=%0d spike=%0d expected 2 0", state_o, spike);
        end
        step(1'b1, VP10, 1'b0);
        checks++;
        if (state_o !== 2'd0 || spike !== 1'b0) begin
            errors++;
            $display("FAIL gate_resume_54: got state=%0d spike=%0d expected 0 0", state_o, spike);
        end
        step(1'b1, VP10, 1'b0);
        checks++;
        if (spike !== 1'b1 || isi_valid !== 1'b1 || isi !== 16'd66) begin
            errors++;
            $display("FAIL gate_isi: got spike=%0d isi_valid=%0d isi=%0d expected 1 1 66", spike, isi_valid, isi);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            step(1'b1, (i % 2 == 0) ? VP10 : VM65, 1'b0);
            checks++;
            if (s_i_syn[13] !== 1'b0) begin
                errors++;
                $display("FAIL sat_nowrap_%0d: got i_syn=%0h expected bit13=0", i, s_i_syn);
            end
            if (i >= 60) begin
                checks++;
                if (s_i_syn !== ((i % 2 == 0) ? 14'h1FFF : 14'h1C00)) begin
                    errors++;
                    $display("FAIL sat_level_%0d: got i_syn=%0h expected %0h", i, s_i_syn,
                             (i % 2 == 0) ? 14'h1FFF : 14'h1C00);
                end
            end
            if (i == 78) begin
                checks++;
                if (s_spike !== 1'b1 || s_isi_valid !== 1'b1 || s_isi !== 4'd2) begin
                    errors++;
                    $display("FAIL sat_isi2: got spike=%0d isi_valid=%0d isi=%0d expected 1 1 2", s_spike, s_isi_valid, s_isi);
                end
            end
        end
        checks++;
        if (s_count !== 4'd15) begin
            errors++;
            $display("FAIL cnt_sat: got %0d expected 15", s_count);
        end
        for (int i = 0; i < 20; i++) step(1'b1, VM65, 1'b0);
        step(1'b1, VP10, 1'b0);
        checks++;
        if (s_spike !== 1'b1 || s_isi !== 4'd15) begin
            errors++;
            $display("FAIL isi_sat: got spike=%0d isi=%0d expected 1 15", s_spike, s_isi);
        end
        step(1'b1, VM65, 1'b0);
        step(1'b1, VP10, 1'b1);
        checks++;
        if (s_spike !== 1'b1 || s_count !== 4'd1) begin
            errors++;
            $display("FAIL clr_with_spike: got spike=%0d cnt=%0d expected 1 1", s_spike, s_count);
        end
        step(1'b0, VM65, 1'b1);
        checks++;
        if (s_count !== 4'd0) begin
            errors++;
            $display("FAIL clr_alone: got cnt=%0d expected 0", s_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(1'b1, VP10, 1'b0);
        step(1'b1, VM65, 1'b0);
        step(1'b1, VM65, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spike, isi_valid, isi, spike_count, i_syn, state_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: got cnt=%0d i_syn=%0h state=%0d isi=%0d expected all 0",
                     spike_count, i_syn, state_o, isi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, VP10, 1'b0);
        checks++;
        if (spike !== 1'b1 || isi_valid !== 1'b0 || spike_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_reset_spike: got spike=%0d isi_valid=%0d cnt=%0d expected 1 0 1", spike, isi_valid, spike_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_hysteresis();
        test_refrac_isi();
        test_en_gating();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
